data_mem_ctrl: RTL and testbench

Data-memory controller directly downstream of the MEM stage. It consumes the stage's address, store data, read/write enables and byte-lane masks, and performs the access on an internal word-organised synchronous RAM with a configurable number of wait states. It stalls the pipeline until the access completes and returns lane-aligned, sign- or zero-extended load data for writeback.

---
 rtl/data_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word RAM behind the MEM stage with wait states, stall and extended loads.
// Define DMEM_MISALIGN_CHECK_EN to flag illegal lane/offset combinations on memErr_o.
module data_mem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] wtData_i,
    input  logic        W_MEM_EN_i,
    input  logic        R_MEM_EN_i,
    input  logic [3:0]  W_MASK_i,
    input  logic [3:0]  R_MASK_i,
    input  logic        rdSigned_i,
    output logic [31:0] rdData_o,
    output logic        memAck_o,
    output logic        memStall_o,
    output logic        memErr_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rd_q, rd_d;
    logic          err_q, err_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d, re_q, re_d, sgn_q, sgn_d;
    logic [3:0]    wmask_q, wmask_d, rmask_q, rmask_d;

    logic [31:0]   mem [DEPTH];

    logic          req, commit, err_cond, do_write;
    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_we, sel_re, sel_sgn;
    logic [3:0]    sel_wmask, sel_rmask, chk_mask;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [31:0]   ram_rd, wdata_sh, ld_shift, ld_ext;
    logic [2:0]    pc;

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic lane_legal(input logic [3:0] m, input logic [1:0] o);
        return (m == (4'b0001 << o)) || (m == 4'b0011 && o == 2'd0) ||
               (m == 4'b1100 && o == 2'd2) || (m == 4'b1111 && o == 2'd0);
    endfunction
`endif

    assign req = W_MEM_EN_i | R_MEM_EN_i;

    // Inputs are only trusted in IDLE; later cycles use the captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            sel_addr  = memAddr_i[AW+1:0];
            sel_wdata = wtData_i;
            sel_we    = W_MEM_EN_i;
            sel_re    = R_MEM_EN_i;
            sel_wmask = W_MASK_i;
            sel_rmask = R_MASK_i;
            sel_sgn   = rdSigned_i;
        end else begin
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
            sel_we    = we_q;
            sel_re    = re_q;
            sel_wmask = wmask_q;
            sel_rmask = rmask_q;
            sel_sgn   = sgn_q;
        end
    end

    assign off      = sel_addr[1:0];
    assign idx      = sel_addr[AW+1:2];
    assign chk_mask = sel_we ? sel_wmask : sel_rmask;
    assign ram_rd   = mem[idx];
    assign wdata_sh = sel_wdata << {off, 3'b000};
    assign pc       = {2'b0, sel_rmask[0]} + {2'b0, sel_rmask[1]} +
                      {2'b0, sel_rmask[2]} + {2'b0, sel_rmask[3]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_cond = ~lane_legal(chk_mask, off);
`else
    assign err_cond = 1'b0;
`endif

    always_comb begin
        ld_shift = (ram_rd & {{8{sel_rmask[3]}}, {8{sel_rmask[2]}},
                              {8{sel_rmask[1]}}, {8{sel_rmask[0]}}}) >> {off, 3'b000};
        case (pc)
            3'd1:    ld_ext = {{24{sel_sgn & ld_shift[7]}}, ld_shift[7:0]};
            3'd2:    ld_ext = {{16{sel_sgn & ld_shift[15]}}, ld_shift[15:0]};
            3'd3:    ld_ext = {8'h00, ld_shift[23:0]};
            3'd4:    ld_ext = ld_shift;
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        wmask_d = wmask_q;
        rmask_d = rmask_q;
        sgn_d   = sgn_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    re_d    = sel_re;
                    wmask_d = sel_wmask;
                    rmask_d = sel_rmask;
                    sgn_d   = sel_sgn;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d  = rd_q;
        err_d = commit & err_cond;
        if (commit) begin
            if (err_cond || (sel_we && sel_re)) begin
                rd_d = 32'h0;
            end else if (sel_re) begin
                rd_d = ld_ext;
            end
        end
    end

    // Gate with rst_n so a request held during reset never reaches the RAM.
    assign do_write = commit & sel_we & ~err_cond & rst_n;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write && sel_wmask[i]) begin
                mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wmask_q <= 4'h0;
            rmask_q <= 4'h0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wmask_q <= wmask_d;
            rmask_q <= rmask_d;
            sgn_q   <= sgn_d;
        end
    end

    assign rdData_o   = rd_q;
    assign memAck_o   = (state_q == DONE);
    assign memErr_o   = (state_q == DONE) & err_q;
    assign memStall_o = ((state_q == IDLE) & req) | (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a zero-wait and a three-wait instance, directed cases plus random traffic
// checked against a byte-lane memory model.
module tb_data_mem_ctrl;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        we [2], re [2], sg [2];
    logic [3:0]  wm [2], rm [2];
    logic [31:0] rd [2];
    logic        ack [2], stall [2], err [2];

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .memAddr_i(addr[0]), .wtData_i(wdata[0]),
        .W_MEM_EN_i(we[0]), .R_MEM_EN_i(re[0]), .W_MASK_i(wm[0]), .R_MASK_i(rm[0]),
        .rdSigned_i(sg[0]), .rdData_o(rd[0]), .memAck_o(ack[0]), .memStall_o(stall[0]),
        .memErr_o(err[0])
    );

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .memAddr_i(addr[1]), .wtData_i(wdata[1]),
        .W_MEM_EN_i(we[1]), .R_MEM_EN_i(re[1]), .W_MASK_i(wm[1]), .R_MASK_i(rm[1]),
        .rdSigned_i(sg[1]), .rdData_o(rd[1]), .memAck_o(ack[1]), .memStall_o(stall[1]),
        .memErr_o(err[1])
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat_o, stall_o;
    logic        got_ack, err_o, stall_ack;
    logic [31:0] rd_o;
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];

    // Reference: memory update as a set of independently written bytes.
    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] off, input logic [3:0] m);
        logic [31:0] r;
        logic [63:0] sh;
        r  = old;
        sh = {32'h0, d} << (8 * int'(off));
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = sh[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [3:0] m, input logic s);
        logic [31:0] r;
        int n;
        r = 32'h0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                n++;
                if (i >= int'(off)) r[8*(i-int'(off)) +: 8] = word[8*i +: 8];
            end
        end
        if (s && (n == 1 || n == 2) && r[8*n-1]) for (int b = 8*n; b < 32; b++) r[b] = 1'b1;
        return r;
    endfunction

    // Legal: contiguous run of 1, 2 or 4 lanes starting at the offset, naturally aligned.
    function automatic logic m_legal(input logic [3:0] m, input logic [1:0] off);
        int n;
        logic [3:0] run;
        n = int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if ((int'(off) % n) != 0) return 1'b0;
        run = 4'((1 << n) - 1);
        return m == 4'(run << off);
    endfunction

    task automatic access(input int k, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] wmk, input logic [3:0] rmk,
                          input logic s);
        addr[k] = a; wdata[k] = d; wm[k] = wmk; rm[k] = rmk; sg[k] = s;
        we[k] = w; re[k] = r;
        lat_o = 0; stall_o = 0; got_ack = 1'b0; err_o = 1'b0; stall_ack = 1'b0; rd_o = 32'h0;
        while (!got_ack && lat_o < 40) begin
            @(negedge clk);
            if (ack[k]) begin
                got_ack = 1'b1; rd_o = rd[k]; err_o = err[k]; stall_ack = stall[k];
            end else begin
                if (stall[k]) stall_o++;
                @(posedge clk); #1;
                lat_o++;
            end
        end
        we[k] = 1'b0; re[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({rd[k], ack[k], stall[k], err[k]} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: rd=%h ack=%b stall=%b err=%b want all 0",
                         k, rd[k], ack[k], stall[k], err[k]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 0);
        n_checks++;
        if (!got_ack || lat_o != 1 || stall_o != 1 || stall_ack !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_timing: ack=%b lat=%0d stall=%0d stall_done=%b err=%b want 1 1 1 0 0",
                     got_ack, lat_o, stall_o, stall_ack, err_o);
        end
        access(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0);
        n_checks++;
        if (!got_ack || lat_o != 1 || rd_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_word: ack=%b lat=%0d rd=%h want 1 1 deadbeef", got_ack, lat_o, rd_o);
        end
    endtask

    task automatic test_extension();
        logic [31:0] a [4];
        logic [3:0]  m [4];
        logic        s [4];
        logic [31:0] exp [4];
        a = '{32'h23, 32'h22, 32'h20, 32'h22};
        m = '{4'b1000, 4'b0100, 4'b0011, 4'b1100};
        s = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'hFFFF80FF};
        access(0, 1, 0, 32'h20, 32'h80FF7F01, 4'hF, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            access(0, 0, 1, a[i], 32'h0, 4'h0, m[i], s[i]);
            n_checks++;
            if (!got_ack || rd_o !== exp[i]) begin
                n_fail++;
                $display("FAIL ext[%0d]: ack=%b rd=%h want %h", i, got_ack, rd_o, exp[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        access(0, 1, 0, 32'h30, 32'h11223344, 4'hF, 4'h0, 0);
        access(0, 1, 0, 32'h31, 32'h000000AA, 4'b0010, 4'h0, 0);
        n_checks++;
        if (!got_ack || rd_o !== 32'hFFFF80FF) begin
            n_fail++;
            $display("FAIL sb_keeps_rd: ack=%b rd=%h want ffff80ff", got_ack, rd_o);
        end
        access(0, 0, 1, 32'h30, 32'h0, 4'h0, 4'hF, 0);
        n_checks++;
        if (rd_o !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL sb_merge: rd=%h want 1122aa44", rd_o);
        end
    endtask

    task automatic test_wait_states();
        access(1, 1, 0, 32'h50, 32'h0BADF00D, 4'hF, 4'h0, 0);
        n_checks++;
        if (!got_ack || lat_o != 4 || stall_o != 4 || stall_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_sw: ack=%b lat=%0d stall=%0d stall_done=%b want 1 4 4 0",
                     got_ack, lat_o, stall_o, stall_ack);
        end
        access(1, 0, 1, 32'h50, 32'h0, 4'h0, 4'hF, 0);
        n_checks++;
        if (!got_ack || lat_o != 4 || stall_o != 4 || rd_o !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL wait_b2b_lw: ack=%b lat=%0d stall=%0d rd=%h want 1 4 4 0badf00d",
                     got_ack, lat_o, stall_o, rd_o);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        access(1, 1, 0, 32'h40, 32'h5A5A1234, 4'hF, 4'h0, 0);
        addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; wm[1] = 4'hF; we[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; we[1] = 1'b0;
        #1;
        n_checks++;
        if ({rd[1], ack[1], stall[1], err[1]} !== 35'h0) begin
            n_fail++;
            $display("FAIL mid_reset_out: rd=%h ack=%b stall=%b err=%b want all 0",
                     rd[1], ack[1], stall[1], err[1]);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack[1]) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack[1]) seen = 1'b1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ack: ack seen=%b want 0", seen);
        end
        access(1, 0, 1, 32'h40, 32'h0, 4'h0, 4'hF, 0);
        n_checks++;
        if (!got_ack || rd_o !== 32'h5A5A1234) begin
            n_fail++;
            $display("FAIL mid_reset_ram: ack=%b rd=%h want 5a5a1234", got_ack, rd_o);
        end
    endtask

    task automatic test_misalign();
        logic        exp_err;
        logic [31:0] exp_rd, exp_word;
        access(0, 1, 0, 32'h40, 32'h01020304, 4'hF, 4'h0, 0);
        access(0, 0, 1, 32'h40, 32'h0, 4'h0, 4'hF, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_err = !m_legal(4'hF, 2'd2);
`else
        exp_err = 1'b0;
`endif
        exp_rd   = exp_err ? 32'h0 : 32'h01020304;
        exp_word = exp_err ? 32'h01020304 : m_store(32'h01020304, 32'hCAFEBABE, 2'd2, 4'hF);
        access(0, 1, 0, 32'h42, 32'hCAFEBABE, 4'hF, 4'h0, 0);
        n_checks++;
        if (!got_ack || err_o !== exp_err || rd_o !== exp_rd) begin
            n_fail++;
            $display("FAIL misalign_sw: ack=%b err=%b rd=%h want 1 %b %h",
                     got_ack, err_o, rd_o, exp_err, exp_rd);
        end
        @(negedge clk);
        n_checks++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idle: err=%b want 0", err[0]);
        end
        @(posedge clk); #1;
        access(0, 0, 1, 32'h40, 32'h0, 4'h0, 4'hF, 0);
        n_checks++;
        if (rd_o !== exp_word) begin
            n_fail++;
            $display("FAIL misalign_ram: rd=%h want %h", rd_o, exp_word);
        end
    endtask

    task automatic test_random(input int k, input int n_ops);
        int          wi, sz, op;
        logic [1:0]  off;
        logic [3:0]  m, m2;
        logic [31:0] a, d, exp;
        for (int w = 64; w < 80; w++) begin
            d = $urandom;
            access(k, 1, 0, ($urandom & 32'hFFFFFC00) | 32'(w << 2), d, 4'hF, 4'h0, 0);
            mdl[k][w] = d;
        end
        access(k, 0, 1, 32'h100, 32'h0, 4'h0, 4'hF, 0);
        last_rd[k] = mdl[k][64];
        n_checks++;
        if (rd_o !== last_rd[k]) begin
            n_fail++;
            $display("FAIL rnd_init[%0d]: rd=%h want %h", k, rd_o, last_rd[k]);
        end
        for (int i = 0; i < n_ops; i++) begin
            wi = 64 + $urandom_range(0, 15);
            sz = $urandom_range(0, 2);
            if (sz == 0) begin
                off = 2'($urandom_range(0, 3)); m = 4'b0001 << off;
            end else if (sz == 1) begin
                off = 2'(2 * $urandom_range(0, 1)); m = 4'b0011 << off;
            end else begin
                off = 2'd0; m = 4'hF;
            end
            a  = ($urandom & 32'hFFFFFC00) | 32'(wi << 2) | 32'(off);
            d  = $urandom;
            op = $urandom_range(0, 9);
            m2 = (op == 9) ? 4'hF : m;
            if (op < 4) begin
                access(k, 0, 1, a, d, 4'h0, m, op[0]);
                last_rd[k] = m_load(mdl[k][wi], off, m, op[0]);
            end else begin
                access(k, 1, op == 9, a, d, m, m2, 1'b1);
                mdl[k][wi] = m_store(mdl[k][wi], d, off, m);
                if (op == 9) last_rd[k] = 32'h0;
            end
            exp = last_rd[k];
            n_checks++;
            if (!got_ack || lat_o != (k == 0 ? 1 : 4) || err_o !== 1'b0 || rd_o !== exp) begin
                n_fail++;
                $display("FAIL rnd[%0d.%0d] op=%0d a=%h m=%b: ack=%b lat=%0d err=%b rd=%h want rd=%h",
                         k, i, op, a, m, got_ack, lat_o, err_o, rd_o, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            addr[k] = 32'h0; wdata[k] = 32'h0; we[k] = 1'b0; re[k] = 1'b0;
            wm[k] = 4'h0; rm[k] = 4'h0; sg[k] = 1'b0;
        end
        test_reset();
        test_word();
        test_extension();
        test_partial_store();
        test_wait_states();
        test_reset_mid();
        test_misalign();
        test_random(0, 80);
        test_random(1, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
